sram_bus_arbiter: RTL and testbench
===================================

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter DW, default 32, SRAM data width in bits.
REQ-002 Parameter AW, default 7, SRAM address width in bits.
REQ-003 Parameter RD_LAT, default 1, range 1..4, cycles from read issue to data valid at requester.
REQ-004 Parameter MAX_WAIT, default 16, host starvation limit in cycles (used only with SRAM_ARB_STARVE_EN).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 h_req  in  1  host (testbench) access request.
REQ-008 h_wen  in  1  host write-enable, active-low (0 = write).
REQ-009 h_a / h_d  in  AW / DW  host address / write data.
REQ-010 h_gnt  out  1  host owns SRAM bus.
REQ-011 h_rvalid / h_q  out  1 / DW  host read-data valid / data.
REQ-012 c_req, c_wen, c_a, c_d, c_gnt, c_rvalid, c_q: controller port, identical widths and meanings to the host port.
REQ-013 m_cen / m_wen  out  1 / 1  SRAM chip-enable / write-enable, both active-low.
REQ-014 m_a / m_d  out  AW / DW  SRAM address / write data.
REQ-015 m_q  in  DW  SRAM read data, valid one cycle after read issue.
REQ-016 owner  out  2  00 IDLE, 01 HOST, 10 CTRL, 11 TURN.

Function
REQ-017 FSM states IDLE, HOST, CTRL, TURN; owner mirrors state; h_gnt=1 only in HOST, c_gnt=1 only in CTRL (registered).
REQ-018 IDLE: c_req=1 -> CTRL; else h_req=1 -> HOST; simultaneous requests -> CTRL wins.
REQ-019 HOST/CTRL: stay while owner's req=1; on owner's req=0 -> TURN.
REQ-020 TURN lasts exactly RD_LAT cycles, then -> CTRL if c_req, else HOST if h_req, else IDLE (controller priority).
REQ-021 Access issued in a cycle iff owner's req=1 and its gnt=1: m_cen=0, m_wen/m_a/m_d driven combinationally from owner's port; otherwise m_cen=1, m_wen=1, m_a=0, m_d=0.
REQ-022 One access per cycle, back-to-back allowed; writes produce no rvalid.
REQ-023 Each read is tagged with its issuer in an RD_LAT-deep shift register; rvalid pulses on that requester's port exactly RD_LAT cycles after issue, independent of later ownership changes.
REQ-024 m_q is delayed RD_LAT-1 register stages before driving h_q/c_q; both data outputs carry the same delayed data; only rvalid distinguishes them.
REQ-025 Requests from a non-owner are held pending, never dropped, never issued.
REQ-026 TURN guarantees no two requesters' read data is in flight when ownership changes.

Reset
REQ-027 reset=0 asynchronously forces state IDLE, owner=00, h_gnt=c_gnt=0, h_rvalid=c_rvalid=0, tag pipeline cleared, data stages cleared to 0, starvation counter 0.
REQ-028 Reset mid-read discards in-flight reads: no rvalid after reset release.
REQ-029 First grant possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro SRAM_ARB_STARVE_EN defined: counter increments each cycle state=CTRL and h_req=1, otherwise clears; on reaching MAX_WAIT the FSM -> TURN, then -> HOST, overriding controller priority for that one handover.
REQ-031 Macro SRAM_ARB_STARVE_EN undefined: no counter logic; controller holds bus indefinitely while c_req=1.

Verification
REQ-032 Reset, h_req=1 write a=5 d=0xA5A5A5A5, then read a=5 -> h_gnt high next cycle, m_cen=0, m_wen=0 then 1; h_rvalid=1 with h_q=0xA5A5A5A5 RD_LAT cycles after read.
REQ-033 h_req and c_req rise same cycle from IDLE -> owner=10, c_gnt=1, h_gnt=0; c_req drop -> TURN for RD_LAT cycles -> owner=01.
REQ-034 RD_LAT=3, controller reads a=0..3 back-to-back then releases while h_req=1 -> four c_rvalid pulses, zero h_rvalid pulses, h_gnt rises only after TURN.
REQ-035 Assert reset=0 one cycle after a controller read issue -> no c_rvalid ever; all outputs at reset values during and after reset.
REQ-036 SRAM_ARB_STARVE_EN, MAX_WAIT=4, c_req held high, h_req=1 -> c_gnt falls after 4 waiting cycles, TURN RD_LAT cycles, then h_gnt=1; without macro h_gnt stays 0 for 100 cycles.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-port SRAM bus arbiter: host and controller share one single-port SRAM, controller has priority.
// Optional host starvation guard enabled by defining SRAM_ARB_STARVE_EN.
module sram_bus_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 7,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          h_req,
    input  logic          h_wen,
    input  logic [AW-1:0] h_a,
    input  logic [DW-1:0] h_d,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_q,
    input  logic          c_req,
    input  logic          c_wen,
    input  logic [AW-1:0] c_a,
    input  logic [DW-1:0] c_d,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_q,
    output logic          m_cen,
    output logic          m_wen,
    output logic [AW-1:0] m_a,
    output logic [DW-1:0] m_d,
    input  logic [DW-1:0] m_q,
    output logic [1:0]    owner
);

    // state | meaning
    // IDLE  | bus free, no requester owns it
    // HOST  | host owns the bus
    // CTRL  | controller owns the bus
    // TURN  | RD_LAT-cycle gap so in-flight reads drain before handover
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOST = 2'b01;
    localparam logic [1:0] ST_CTRL = 2'b10;
    localparam logic [1:0] ST_TURN = 2'b11;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        turn_cnt;
    logic              turn_done;
    logic              h_issue;
    logic              c_issue;
    logic [RD_LAT-1:0] tag_h;
    logic [RD_LAT-1:0] tag_c;
    logic [DW-1:0]     q_dly;
    logic              starve_hit;
    logic              starve_flag;

    assign h_issue   = h_req & h_gnt;
    assign c_issue   = c_req & c_gnt;
    assign turn_done = (turn_cnt == 2'd0);

`ifdef SRAM_ARB_STARVE_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] starve_cnt;

    // Fires in the cycle the wait count would reach MAX_WAIT.
    assign starve_hit = (state == ST_CTRL) && h_req && (starve_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
        end else begin
            if ((state == ST_CTRL) && h_req)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
            if (starve_hit)
                starve_flag <= 1'b1;
            else if ((state == ST_TURN) && turn_done)
                starve_flag <= 1'b0;
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
    assign starve_hit      = 1'b0;
    assign starve_flag     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (c_req)      state_nxt = ST_CTRL;
                else if (h_req) state_nxt = ST_HOST;
            end
            ST_HOST: if (!h_req) state_nxt = ST_TURN;
            ST_CTRL: if (!c_req || starve_hit) state_nxt = ST_TURN;
            ST_TURN: begin
                if (turn_done) begin
                    if (starve_flag && h_req) state_nxt = ST_HOST;
                    else if (c_req)           state_nxt = ST_CTRL;
                    else if (h_req)           state_nxt = ST_HOST;
                    else                      state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // turn_cnt is a down-counter preloaded outside TURN, so TURN lasts RD_LAT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            turn_cnt <= 2'(RD_LAT - 1);
        end else begin
            state <= state_nxt;
            if (state != ST_TURN)
                turn_cnt <= 2'(RD_LAT - 1);
            else if (!turn_done)
                turn_cnt <= turn_cnt - 2'd1;
        end
    end

    assign owner = state;
    assign h_gnt = (state == ST_HOST);
    assign c_gnt = (state == ST_CTRL);

    always_comb begin
        m_cen = 1'b1;
        m_wen = 1'b1;
        m_a   = '0;
        m_d   = '0;
        if (c_issue) begin
            m_cen = 1'b0;
            m_wen = c_wen;
            m_a   = c_a;
            m_d   = c_d;
        end else if (h_issue) begin
            m_cen = 1'b0;
            m_wen = h_wen;
            m_a   = h_a;
            m_d   = h_d;
        end
    end

    // Read tags follow the issuer, not the current owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_h <= '0;
            tag_c <= '0;
        end else begin
            tag_h[0] <= h_issue & h_wen;
            tag_c[0] <= c_issue & c_wen;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_h[i] <= tag_h[i-1];
                tag_c[i] <= tag_c[i-1];
            end
        end
    end

    assign h_rvalid = tag_h[RD_LAT-1];
    assign c_rvalid = tag_c[RD_LAT-1];

    generate
        if (RD_LAT == 1) begin : g_no_dly
            assign q_dly = m_q;
        end else begin : g_dly
            logic [DW-1:0] dstage [RD_LAT-1];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < RD_LAT - 1; i++) dstage[i] <= '0;
                end else begin
                    dstage[0] <= m_q;
                    for (int i = 1; i < RD_LAT - 1; i++) dstage[i] <= dstage[i-1];
                end
            end
            assign q_dly = dstage[RD_LAT-2];
        end
    endgenerate

    assign h_q = q_dly;
    assign c_q = q_dly;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (RD_LAT=3, MAX_WAIT=4) with a behavioural SRAM model.
module tb_sram_bus_arbiter;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NV = 33;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          h_req, h_wen, c_req, c_wen;
    logic [AW-1:0] h_a, c_a;
    logic [DW-1:0] h_d, c_d;
    logic          h_gnt, h_rvalid, c_gnt, c_rvalid;
    logic [DW-1:0] h_q, c_q;
    logic          m_cen, m_wen;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic [DW-1:0] m_q = '0;
    logic [1:0]    owner;

    sram_bus_arbiter #(.DW(DW), .AW(AW), .RD_LAT(3), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_wen(h_wen), .h_a(h_a), .h_d(h_d),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_q(h_q),
        .c_req(c_req), .c_wen(c_wen), .c_a(c_a), .c_d(c_d),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_q(c_q),
        .m_cen(m_cen), .m_wen(m_wen), .m_a(m_a), .m_d(m_d), .m_q(m_q),
        .owner(owner)
    );

    // SRAM: power-on pattern 0x1000_0000 + addr, read data valid one cycle after issue.
    logic [DW-1:0] mem [128];
    bit mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + i;
            mem_ready <= 1'b1;
        end else if (!m_cen) begin
            if (!m_wen) mem[m_a] <= m_d;
            else        m_q <= mem[m_a];
        end
    end

    typedef struct {
        logic [31:0] hq, hw, ha, hd, cq, cw, ca, cd;
        logic [31:0] own, hg, cg, cen, wen, ea, ed, hrv, crv, eq;
    } vec_t;

    vec_t vecs [NV];
    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(input logic [31:0] hq, hw, ha, hd, cq, cw, ca, cd,
                                own, hg, cg, cen, wen, ea, ed, hrv, crv, eq);
        vec_t v;
        v.hq = hq; v.hw = hw; v.ha = ha; v.hd = hd;
        v.cq = cq; v.cw = cw; v.ca = ca; v.cd = cd;
        v.own = own; v.hg = hg; v.cg = cg; v.cen = cen; v.wen = wen;
        v.ea = ea; v.ed = ed; v.hrv = hrv; v.crv = crv; v.eq = eq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hq, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                         input logic cq, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        h_req = hq; h_wen = hw; h_a = ha; h_d = hd;
        c_req = cq; c_wen = cw; c_a = ca; c_d = cd;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " owner"},    32'(owner),    32'd0);
        chk({tag, " h_gnt"},    32'(h_gnt),    32'd0);
        chk({tag, " c_gnt"},    32'(c_gnt),    32'd0);
        chk({tag, " h_rvalid"}, 32'(h_rvalid), 32'd0);
        chk({tag, " c_rvalid"}, 32'(c_rvalid), 32'd0);
        chk({tag, " m_cen"},    32'(m_cen),    32'd1);
    endtask

    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    initial begin
        //             host: req wen a  d    ctrl: req wen a d | own hg cg cen wen a d  hrv crv q
        vecs[0]  = mk(1, 0, 5, A5, 0, 1, 0, 0,    0, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[1]  = mk(1, 0, 5, A5, 0, 1, 0, 0,    1, 1, 0, 0, 0, 5, A5, 0, 0, 0);
        vecs[2]  = mk(1, 1, 5, 0,  0, 1, 0, 0,    1, 1, 0, 0, 1, 5, 0,  0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0,  0, 1, 0, 0,    1, 1, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  1, 0, A5);
        vecs[6]  = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[7]  = mk(1, 1, 2, 0,  1, 0, 2, 32'h22, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 2, 0,  1, 0, 2, 32'h22, 2, 0, 1, 0, 0, 2, 32'h22, 0, 0, 0);
        vecs[9]  = mk(1, 1, 2, 0,  0, 1, 0, 0,    2, 0, 1, 1, 1, 0, 0,  0, 0, 0);
        vecs[10] = mk(1, 1, 2, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[11] = mk(1, 1, 2, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[12] = mk(1, 1, 2, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[13] = mk(1, 1, 2, 0,  0, 1, 0, 0,    1, 1, 0, 0, 1, 2, 0,  0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0,  0, 1, 0, 0,    1, 1, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[15] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[16] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  1, 0, 32'h22);
        vecs[17] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[18] = mk(1, 1, 5, 0,  1, 1, 0, 0,    0, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[19] = mk(1, 1, 5, 0,  1, 1, 0, 0,    2, 0, 1, 0, 1, 0, 0,  0, 0, 0);
        vecs[20] = mk(1, 1, 5, 0,  1, 1, 1, 0,    2, 0, 1, 0, 1, 1, 0,  0, 0, 0);
        vecs[21] = mk(1, 1, 5, 0,  1, 1, 2, 0,    2, 0, 1, 0, 1, 2, 0,  0, 0, 0);
        vecs[22] = mk(1, 1, 5, 0,  1, 1, 3, 0,    2, 0, 1, 0, 1, 3, 0,  0, 1, 32'h1000_0000);
        vecs[23] = mk(1, 1, 5, 0,  0, 1, 0, 0,    2, 0, 1, 1, 1, 0, 0,  0, 1, 32'h1000_0001);
        vecs[24] = mk(1, 1, 5, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 1, 32'h22);
        vecs[25] = mk(1, 1, 5, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 1, 32'h1000_0003);
        vecs[26] = mk(1, 1, 5, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[27] = mk(1, 1, 5, 0,  0, 1, 0, 0,    1, 1, 0, 0, 1, 5, 0,  0, 0, 0);
        vecs[28] = mk(0, 1, 0, 0,  0, 1, 0, 0,    1, 1, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[29] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[30] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  1, 0, A5);
        vecs[31] = mk(0, 1, 0, 0,  0, 1, 0, 0,    3, 0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[32] = mk(0, 1, 0, 0,  0, 1, 0, 0,    0, 0, 0, 1, 1, 0, 0,  0, 0, 0);

        reset = 1'b0;
        drive(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            h_req = vecs[i].hq[0]; h_wen = vecs[i].hw[0]; h_a = vecs[i].ha[AW-1:0]; h_d = vecs[i].hd;
            c_req = vecs[i].cq[0]; c_wen = vecs[i].cw[0]; c_a = vecs[i].ca[AW-1:0]; c_d = vecs[i].cd;
            #1;
            chk($sformatf("v%0d owner", i),    32'(owner),    vecs[i].own);
            chk($sformatf("v%0d h_gnt", i),    32'(h_gnt),    vecs[i].hg);
            chk($sformatf("v%0d c_gnt", i),    32'(c_gnt),    vecs[i].cg);
            chk($sformatf("v%0d m_cen", i),    32'(m_cen),    vecs[i].cen);
            chk($sformatf("v%0d m_wen", i),    32'(m_wen),    vecs[i].wen);
            chk($sformatf("v%0d m_a", i),      32'(m_a),      vecs[i].ea);
            chk($sformatf("v%0d m_d", i),      m_d,           vecs[i].ed);
            chk($sformatf("v%0d h_rvalid", i), 32'(h_rvalid), vecs[i].hrv);
            chk($sformatf("v%0d c_rvalid", i), 32'(c_rvalid), vecs[i].crv);
            if (vecs[i].hrv[0]) chk($sformatf("v%0d h_q", i), h_q, vecs[i].eq);
            if (vecs[i].crv[0]) chk($sformatf("v%0d c_q", i), c_q, vecs[i].eq);
            @(posedge clk);
            #1;
        end

        // Reset one cycle after a controller read issue discards the read.
        drive(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 7'd1, '0);
        tick();
        #1;
        chk("rst_mid issue m_cen", 32'(m_cen), 32'd0);
        tick();
        reset = 1'b0;
        c_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_idle_outputs($sformatf("rst_mid hold%0d", k));
            chk($sformatf("rst_mid hold%0d h_q", k), h_q, 32'd0);
            chk($sformatf("rst_mid hold%0d c_q", k), c_q, 32'd0);
            if (k < 2) tick();
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rst_after%0d c_rvalid", k), 32'(c_rvalid), 32'd0);
            chk($sformatf("rst_after%0d owner", k), 32'(owner), 32'd0);
            tick();
        end

        // Controller holds the bus with continuous writes while the host waits.
        drive(1'b1, 1'b1, 7'd5, '0, 1'b1, 1'b0, 7'd7, 32'h77);
`ifdef SRAM_ARB_STARVE_EN
        begin
            logic [1:0] exp_seq [9];
            exp_seq = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
            for (int k = 0; k < 9; k++) begin
                #1;
                chk($sformatf("starve%0d owner", k), 32'(owner), 32'(exp_seq[k]));
                tick();
            end
        end
`else
        begin
            int hg_cycles;
            int cg_low;
            hg_cycles = 0;
            cg_low = 0;
            tick();
            for (int k = 0; k < 100; k++) begin
                #1;
                if (h_gnt) hg_cycles++;
                if (!c_gnt) cg_low++;
                tick();
            end
            chk("nostarve h_gnt cycles", 32'(hg_cycles), 32'd0);
            chk("nostarve c_gnt low cycles", 32'(cg_low), 32'd0);
        end
`endif
        begin
            bit seen;
            seen = 1'b0;
            c_req = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                tick();
                if (h_gnt) seen = 1'b1;
            end
            chk("handover h_gnt within bound", 32'(seen), 32'd1);
        end

        drive(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
